mac_lookup_pkt_merge: RTL and testbench

- Packet-path wrapper around the learning MAC CAM lookup core in the switch output port lookup.
- Parses the first beat of each incoming AXI-Stream packet and drives dst_mac/src_mac/src_port with a lookup_req pulse to the core.
- Buffers the packet until the core's lookup_done returns, then writes dst_ports into the first-beat tuser and streams the packet out.
- Supports pipelined back-to-back lookups, with several packets in flight.

---
 rtl/mac_lookup_pkt_merge.sv | 233 +++++++++++++++++++++++
 tb/tb_mac_lookup_pkt_merge.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_lookup_pkt_merge.sv
// mac_lookup_pkt_merge: packet-path wrapper around the MAC CAM lookup core.
// The first beat of each packet is parsed into a lookup request. The whole packet
// is buffered until the core returns its result. The packet is then emitted with
// the result written into tuser[31:24] of its first beat.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IN_HDR   | next accepted input beat is a packet header (issues a lookup)
// IN_BODY  | input is inside a packet; beats go straight to the beat FIFO
// OUT_HDR  | next output beat is a header; it waits for its lookup result
// OUT_BODY | output is inside a packet; beats pass through unmodified
module mac_lookup_pkt_merge #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_OUTPUT_QUEUES    = 8,
  parameter int PKT_FIFO_DEPTH_BITS  = 5,
  parameter int RES_FIFO_DEPTH_BITS  = 2,
  parameter int INIT_CYCLES          = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              lookup_req,
  output logic [47:0]                       dst_mac,
  output logic [47:0]                       src_mac,
  output logic [NUM_OUTPUT_QUEUES-1:0]      src_port,
  input  logic [NUM_OUTPUT_QUEUES-1:0]      dst_ports,
  input  logic                              lookup_done,
  input  logic                              lut_hit,
  input  logic                              lut_miss,
  output logic [31:0]                       pkt_hit_count,
  output logic [31:0]                       pkt_miss_count
);

  localparam int DW  = C_S_AXIS_DATA_WIDTH;
  localparam int KW  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW  = C_S_AXIS_TUSER_WIDTH;
  localparam int NQ  = NUM_OUTPUT_QUEUES;
  localparam int PB  = PKT_FIFO_DEPTH_BITS;
  localparam int RB  = RES_FIFO_DEPTH_BITS;
  localparam int PW  = DW + KW + UW + 1;
  localparam int PKT_DEPTH = 1 << PB;
  localparam int RES_DEPTH = 1 << RB;

  localparam logic [0:0] IN_HDR   = 1'b0;
  localparam logic [0:0] IN_BODY  = 1'b1;
  localparam logic [0:0] OUT_HDR  = 1'b0;
  localparam logic [0:0] OUT_BODY = 1'b1;

  localparam logic [15:0] INIT_LOAD  = 16'(INIT_CYCLES);
  localparam logic [15:0] INIT_ONE   = 16'd1;
  localparam logic [PB:0] PKT_ONE    = (PB+1)'(1);
  localparam logic [RB:0] RES_ONE    = (RB+1)'(1);
  localparam logic [RB:0] CREDIT_MAX = (RB+1)'(RES_DEPTH);
  localparam logic [31:0] CNT_ONE    = 32'd1;

  logic [0:0]    in_state_q, in_state_d;
  logic [0:0]    out_state_q, out_state_d;
  logic [15:0]   init_cnt_q, init_cnt_d;
  logic [RB:0]   credit_q, credit_d;
  logic [PB:0]   pkt_wr_ptr_q, pkt_wr_ptr_d;
  logic [PB:0]   pkt_rd_ptr_q, pkt_rd_ptr_d;
  logic [RB:0]   res_wr_ptr_q, res_wr_ptr_d;
  logic [RB:0]   res_rd_ptr_q, res_rd_ptr_d;
  logic          lookup_req_q, lookup_req_d;
  logic [47:0]   dst_mac_q, dst_mac_d;
  logic [47:0]   src_mac_q, src_mac_d;
  logic [NQ-1:0] src_port_q, src_port_d;
  logic [31:0]   hit_cnt_q, hit_cnt_d;
  logic [31:0]   miss_cnt_q, miss_cnt_d;

  logic [PW-1:0] pkt_mem_q [PKT_DEPTH];
  logic [NQ-1:0] res_mem_q [RES_DEPTH];

  logic          init_done, pkt_full, pkt_empty, res_empty, credit_ok;
  logic          in_fire, issue, out_fire, hdr_pop;
  logic [PW-1:0] pkt_head;
  logic [NQ-1:0] res_head;
  logic [DW-1:0] head_data;
  logic [KW-1:0] head_keep;
  logic [UW-1:0] head_user;
  logic          head_last;

  assign init_done = (init_cnt_q == '0);
  assign pkt_empty = (pkt_wr_ptr_q == pkt_rd_ptr_q);
  assign pkt_full  = (pkt_wr_ptr_q[PB] != pkt_rd_ptr_q[PB]) &&
                     (pkt_wr_ptr_q[PB-1:0] == pkt_rd_ptr_q[PB-1:0]);
  assign res_empty = (res_wr_ptr_q == res_rd_ptr_q);
  // Credit counts lookups issued whose result has not yet been popped, so the
  // result FIFO can never be asked to hold more than it has room for.
  assign credit_ok = (credit_q < CREDIT_MAX);

  assign pkt_head = pkt_mem_q[pkt_rd_ptr_q[PB-1:0]];
  assign res_head = res_mem_q[res_rd_ptr_q[RB-1:0]];
  assign {head_data, head_keep, head_user, head_last} = pkt_head;

  assign s_axis_tready = (in_state_q == IN_HDR) ? (init_done & ~pkt_full & credit_ok)
                                                : ~pkt_full;
  assign in_fire  = s_axis_tvalid & s_axis_tready;
  assign issue    = in_fire & (in_state_q == IN_HDR);

  assign m_axis_tvalid = (out_state_q == OUT_HDR) ? (~pkt_empty & ~res_empty) : ~pkt_empty;
  assign out_fire = m_axis_tvalid & m_axis_tready;
  assign hdr_pop  = out_fire & (out_state_q == OUT_HDR);

  assign m_axis_tdata = head_data;
  assign m_axis_tkeep = head_keep;
  assign m_axis_tlast = head_last;

  assign lookup_req     = lookup_req_q;
  assign dst_mac        = dst_mac_q;
  assign src_mac        = src_mac_q;
  assign src_port       = src_port_q;
  assign pkt_hit_count  = hit_cnt_q;
  assign pkt_miss_count = miss_cnt_q;

  // Header beats carry the lookup result in the destination-port field of tuser.
  always_comb begin
    m_axis_tuser = head_user;
    if (out_state_q == OUT_HDR) begin
      m_axis_tuser[24 +: NQ] = res_head;
    end
  end

  // Beat and result storage; the pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      pkt_mem_q[pkt_wr_ptr_q[PB-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    end
    if (lookup_done) begin
      res_mem_q[res_wr_ptr_q[RB-1:0]] <= dst_ports;
    end
  end

  // Next-state logic for both FSMs, pointers, credit, lookup registers and counters.
  always_comb begin
    in_state_d   = in_state_q;
    out_state_d  = out_state_q;
    init_cnt_d   = (init_cnt_q != '0) ? (init_cnt_q - INIT_ONE) : init_cnt_q;
    credit_d     = credit_q;
    pkt_wr_ptr_d = pkt_wr_ptr_q;
    pkt_rd_ptr_d = pkt_rd_ptr_q;
    res_wr_ptr_d = res_wr_ptr_q;
    res_rd_ptr_d = res_rd_ptr_q;
    lookup_req_d = issue;
    dst_mac_d    = dst_mac_q;
    src_mac_d    = src_mac_q;
    src_port_d   = src_port_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    if (in_fire) begin
      pkt_wr_ptr_d = pkt_wr_ptr_q + PKT_ONE;
      in_state_d   = s_axis_tlast ? IN_HDR : IN_BODY;
    end

    // Byte 0 of the frame is the most significant byte of each MAC.
    if (issue) begin
      for (int b = 0; b < 6; b++) begin
        dst_mac_d[8*(5-b) +: 8] = s_axis_tdata[8*b +: 8];
        src_mac_d[8*(5-b) +: 8] = s_axis_tdata[8*(b+6) +: 8];
      end
      src_port_d = s_axis_tuser[16 +: NQ];
    end

    case ({issue, hdr_pop})
      2'b10:   credit_d = credit_q + RES_ONE;
      2'b01:   credit_d = credit_q - RES_ONE;
      default: credit_d = credit_q;
    endcase

    if (out_fire) begin
      pkt_rd_ptr_d = pkt_rd_ptr_q + PKT_ONE;
      out_state_d  = head_last ? OUT_HDR : OUT_BODY;
    end
    if (hdr_pop) begin
      res_rd_ptr_d = res_rd_ptr_q + RES_ONE;
    end

    if (lookup_done) begin
      res_wr_ptr_d = res_wr_ptr_q + RES_ONE;
      if (lut_hit)  hit_cnt_d  = hit_cnt_q + CNT_ONE;
      if (lut_miss) miss_cnt_d = miss_cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous reset; reset drops any partial packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_q   <= IN_HDR;
      out_state_q  <= OUT_HDR;
      init_cnt_q   <= INIT_LOAD;
      credit_q     <= '0;
      pkt_wr_ptr_q <= '0;
      pkt_rd_ptr_q <= '0;
      res_wr_ptr_q <= '0;
      res_rd_ptr_q <= '0;
      lookup_req_q <= 1'b0;
      dst_mac_q    <= '0;
      src_mac_q    <= '0;
      src_port_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      in_state_q   <= in_state_d;
      out_state_q  <= out_state_d;
      init_cnt_q   <= init_cnt_d;
      credit_q     <= credit_d;
      pkt_wr_ptr_q <= pkt_wr_ptr_d;
      pkt_rd_ptr_q <= pkt_rd_ptr_d;
      res_wr_ptr_q <= res_wr_ptr_d;
      res_rd_ptr_q <= res_rd_ptr_d;
      lookup_req_q <= lookup_req_d;
      dst_mac_q    <= dst_mac_d;
      src_mac_q    <= src_mac_d;
      src_port_q   <= src_port_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_mac_lookup_pkt_merge.sv
// Scoreboard bench for mac_lookup_pkt_merge with a lookup-core stub.
module tb_mac_lookup_pkt_merge;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         lookup_req;
  logic [47:0]  dst_mac;
  logic [47:0]  src_mac;
  logic [7:0]   src_port;
  logic [7:0]   dst_ports;
  logic         lookup_done;
  logic         lut_hit;
  logic         lut_miss;
  logic [31:0]  pkt_hit_count;
  logic [31:0]  pkt_miss_count;

  mac_lookup_pkt_merge dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .lookup_req(lookup_req), .dst_mac(dst_mac), .src_mac(src_mac), .src_port(src_port),
    .dst_ports(dst_ports), .lookup_done(lookup_done), .lut_hit(lut_hit), .lut_miss(lut_miss),
    .pkt_hit_count(pkt_hit_count), .pkt_miss_count(pkt_miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t        exp_out[$];
  logic [103:0] exp_lkp[$];
  logic [9:0]   resp_q[$];
  int           due_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stub_delay = 2;
  int lookup_cnt = 0;
  int out_cnt = 0;
  int beats_acc = 0;
  int hdr_stall = 0;
  int lkp_at_acc = 0;
  int out_at_acc = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  function automatic beat_t make_beat(input int n, input int i, input int tag,
                                      input logic [47:0] dmac, input logic [47:0] smac,
                                      input logic [7:0] sport);
    beat_t b;
    b.d = {8{tag[15:0], i[15:0]}};
    if (i == 0) begin
      for (int j = 0; j < 6; j++) begin
        b.d[8*j +: 8]     = dmac[8*(5-j) +: 8];
        b.d[8*(j+6) +: 8] = smac[8*(5-j) +: 8];
      end
    end
    b.k = (i == n-1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    b.u = {tag[31:0], i[31:0], 32'h1234_5678, 8'hA5, sport, i[15:0]};
    b.l = (i == n-1);
    return b;
  endfunction

  // Lookup-core stub: checks each request and answers it stub_delay cycles later.
  initial begin
    logic [9:0] r;
    lookup_done = 1'b0;
    dst_ports   = '0;
    lut_hit     = 1'b0;
    lut_miss    = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      lookup_done = 1'b0;
      lut_hit     = 1'b0;
      lut_miss    = 1'b0;
      if (reset) begin
        due_q.delete();
      end else begin
        if (lookup_req) begin
          lookup_cnt++;
          if (exp_lkp.size() == 0) fail_now("lookup_unexpected");
          else chk("lookup_fields", {dst_mac, src_mac, src_port}, exp_lkp.pop_front());
          due_q.push_back(cyc + stub_delay);
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          void'(due_q.pop_front());
          if (resp_q.size() == 0) begin
            fail_now("stub_no_response");
          end else begin
            r = resp_q.pop_front();
            lookup_done = 1'b1;
            dst_ports   = r[9:2];
            lut_hit     = r[1];
            lut_miss    = r[0];
          end
        end
      end
    end
  end

  // Output monitor: every output handshake is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && m_axis_tvalid && m_axis_tready) begin
        out_cnt++;
        if (exp_out.size() == 0) fail_now("out_unexpected");
        else chk("out_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast},
                 exp_out.pop_front());
      end
    end
  end

  task automatic drive_beat(input beat_t b, output int stall);
    bit ok = 0;
    int waitc = 0;
    s_axis_tdata  = b.d;
    s_axis_tkeep  = b.k;
    s_axis_tuser  = b.u;
    s_axis_tlast  = b.l;
    s_axis_tvalid = 1'b1;
    while (!ok && waitc < 400) begin
      @(negedge clk);
      if (s_axis_tready && !reset) begin
        ok = 1;
        lkp_at_acc = lookup_cnt;
        out_at_acc = out_cnt;
      end else begin
        waitc++;
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    stall = waitc;
    if (ok) beats_acc++;
    else fail_now("input_handshake_timeout");
  endtask

  task automatic send_pkt(input int n, input int tag, input logic [47:0] dmac,
                          input logic [47:0] smac, input logic [7:0] sport,
                          input logic [7:0] ports, input bit hit, input bit miss);
    beat_t b;
    beat_t e;
    int st;
    exp_lkp.push_back({dmac, smac, sport});
    resp_q.push_back({ports, hit, miss});
    for (int i = 0; i < n; i++) begin
      e = make_beat(n, i, tag, dmac, smac, sport);
      if (i == 0) e.u[31:24] = ports;
      exp_out.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      b = make_beat(n, i, tag, dmac, smac, sport);
      drive_beat(b, st);
      if (i == 0) hdr_stall = st;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_out.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", exp_out.size(), 0);
  endtask

  initial begin
    int base_l;
    int base_o;
    int base_b;
    int n;
    int st;
    beat_t b;
    reset         = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_lookup_req", lookup_req, 0);
    chk("rst_macs", {dst_mac, src_mac, src_port}, 0);
    chk("rst_counts", {pkt_hit_count, pkt_miss_count}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Init hold plus a hit lookup on a single-beat packet.
    send_pkt(1, 1, 48'h001122334455, 48'h66778899AABB, 8'h01, 8'h04, 1'b1, 1'b0);
    chk("init_stall_cycles", hdr_stall, 64);
    wait_drain();
    chk("hit_count_1", pkt_hit_count, 1);
    chk("miss_count_0", pkt_miss_count, 0);

    // Miss result still carries its port vector.
    send_pkt(1, 2, 48'h0A0B0C0D0E0F, 48'h102030405060, 8'h01, 8'h04, 1'b0, 1'b1);
    wait_drain();
    chk("miss_count_1", pkt_miss_count, 1);
    chk("hit_count_hold", pkt_hit_count, 1);

    // Five back-to-back headers with slow results: the fifth waits for a pop.
    stub_delay = 6;
    base_l = lookup_cnt;
    base_o = out_cnt;
    for (int k = 0; k < 4; k++)
      send_pkt(1, 10 + k, 48'hA00000000000 + 48'(k), 48'hB00000000000 + 48'(k),
               8'h02, 8'h01 << k, 1'b1, 1'b0);
    chk("b2b_no_stall", hdr_stall, 0);
    send_pkt(1, 14, 48'hA00000000004, 48'hB00000000004, 8'h02, 8'h80, 1'b1, 1'b0);
    chk("credit_lookups_before_5th", lkp_at_acc - base_l, 4);
    chk("credit_pop_before_5th", (out_at_acc - base_o) >= 1, 1);
    wait_drain();
    chk("b2b_hit_count", pkt_hit_count, 6);
    stub_delay = 2;

    // Long packet against a stalled output: buffer fills at 32 beats.
    m_axis_tready = 1'b0;
    base_b = beats_acc;
    fork
      send_pkt(40, 20, 48'hDEADBEEF0001, 48'hCAFEF00D0002, 8'h08, 8'h10, 1'b1, 1'b0);
    join_none
    repeat (50) @(posedge clk);
    #1;
    chk("long_buffered_beats", beats_acc - base_b, 32);
    m_axis_tready = 1'b1;
    wait_drain();
    n = 0;
    while (beats_acc - base_b < 40 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("long_all_accepted", beats_acc - base_b, 40);
    chk("long_hit_count", pkt_hit_count, 7);

    // Reset in the middle of a 5-beat packet.
    m_axis_tready = 1'b0;
    exp_lkp.push_back({48'h111111111111, 48'h222222222222, 8'h04});
    resp_q.push_back({8'h20, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) begin
      b = make_beat(5, i, 30, 48'h111111111111, 48'h222222222222, 8'h04);
      drive_beat(b, st);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_mvalid", m_axis_tvalid, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_lkp.delete();
    resp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_mvalid", m_axis_tvalid, 0);
    chk("midrst_counts", {pkt_hit_count, pkt_miss_count}, 0);
    chk("midrst_tready", s_axis_tready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_axis_tready = 1'b1;
    send_pkt(2, 31, 48'h333333333333, 48'h444444444444, 8'h04, 8'h02, 1'b1, 1'b0);
    chk("postrst_init_stall", hdr_stall, 64);
    wait_drain();
    chk("postrst_hit_count", pkt_hit_count, 1);
    chk("postrst_miss_count", pkt_miss_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
